// File: rtl/uart_in_pkg.sv
// uart_in_pkg: shared frame constants and receiver state encoding
package uart_in_pkg;
  localparam int DATA_BITS = 8;
  localparam int FRAME_BITS = DATA_BITS + 2;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
endpackage

// File: rtl/uart_in_if.sv
// uart_in_if: received byte and status flags toward the byte consumer
interface uart_in_if;
  import uart_in_pkg::*;
  logic [DATA_BITS-1:0] data;
  logic flag_ready;
  logic flag_error;
  logic flag_busy;
  modport master(output data, flag_ready, flag_error, flag_busy);
  modport slave(input data, flag_ready, flag_error, flag_busy);
endinterface

// File: rtl/uart_in_sync.sv
// uart_sync: N-flop input synchroniser, presets to idle-high, wire when N=0
module uart_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  if (N == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign q = d;
  end else begin : g_ff
    logic [N-1:0] s;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) s <= '1;
      else begin
        s[0] <= d;
        for (int i = 1; i < N; i++) s[i] <= s[i-1];
      end
    assign q = s[N-1];
  end
endmodule

// File: rtl/uart_in.sv
// uart_in: 8N1 UART receiver sampling each bit at its centre
module uart_in
  import uart_in_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  uart_in_if.master bus
);
  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID = CW'(HALF);
  logic line_s;
  state_t st;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [DATA_BITS-1:0] sh;
  uart_sync #(.N(SYNC_STAGES)) u_sync (.clk, .rst_n, .d(in), .q(line_s));
  // Start is re-checked at mid-bit; later samples land one full bit apart from there.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      bus.data <= '0;
      bus.flag_ready <= 1'b0;
      bus.flag_error <= 1'b0;
      bus.flag_busy <= 1'b0;
    end else begin
      bus.flag_ready <= 1'b0;
      bus.flag_error <= 1'b0;
      case (st)
        IDLE:
          if (!line_s) begin
            bus.flag_busy <= 1'b1;
            idx <= '0;
            st <= (HALF == 0) ? DATA : START;
            cnt <= (HALF == 0) ? '0 : CW'(1);
          end
        START:
          if (cnt == MID) begin
            cnt <= '0;
            st <= line_s ? IDLE : DATA;
            bus.flag_busy <= !line_s;
          end else cnt <= cnt + 1'b1;
        DATA:
          if (cnt == LAST) begin
            cnt <= '0;
            sh <= {line_s, sh[DATA_BITS-1:1]};
            idx <= idx + 1'b1;
            if (idx == 3'(DATA_BITS - 1)) st <= STOP;
          end else cnt <= cnt + 1'b1;
        STOP:
          if (cnt == LAST) begin
            cnt <= '0;
            bus.flag_busy <= 1'b0;
            bus.flag_ready <= line_s;
            bus.flag_error <= !line_s;
            if (line_s) bus.data <= sh;
            st <= line_s ? IDLE : BREAK;
          end else cnt <= cnt + 1'b1;
        BREAK:
          if (line_s) st <= IDLE;
        default:
          st <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_in.sv
// tb_uart_in: directed checks of uart_in at 1 and 8 clocks per bit
module tb_uart_in;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_f = 1'b1;
  logic in_s = 1'b1;
  always #5 clk = ~clk;
  uart_in_if bus_f ();
  uart_in_if bus_s ();
  uart_in #(.CLKS_PER_BIT(1), .SYNC_STAGES(0)) u_fast (.clk(clk), .rst_n(rst_n), .in(in_f), .bus(bus_f));
  uart_in #(.CLKS_PER_BIT(8), .SYNC_STAGES(2)) u_slow (.clk(clk), .rst_n(rst_n), .in(in_s), .bus(bus_s));
  int n_chk = 0, n_fail = 0;
  int cyc, rdy_n, rdy_at, err_n, err_at, busy_lo, busy_hi, both_n;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic clr;
    cyc = 0;
    rdy_n = 0;
    rdy_at = -1;
    err_n = 0;
    err_at = -1;
    busy_lo = -1;
    busy_hi = -1;
    both_n = 0;
  endtask
  // Cycle numbers count edges after the line was first driven by this run.
  task automatic run(input logic v, input int n);
    in_s = v;
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus_s.flag_ready) begin rdy_n++; rdy_at = cyc; end
      if (bus_s.flag_error) begin err_n++; err_at = cyc; end
      if (bus_s.flag_ready && bus_s.flag_error) both_n++;
      if (bus_s.flag_busy) begin
        if (busy_lo < 0) busy_lo = cyc;
        busy_hi = cyc;
      end
    end
  endtask
  task automatic frame(input logic [7:0] b, input logic stop);
    run(1'b0, 8);
    for (int k = 0; k < 8; k++) run(b[k], 8);
    run(stop, 8);
  endtask
  logic [7:0] fb[3] = '{8'hA5, 8'h00, 8'hFF};
  logic [29:0] bits;
  int fr_n = 0, fe = 0;
  int fr_at[3] = '{default: 0};
  logic [7:0] fr_d[3] = '{default: 8'h00};
  logic [7:0] b55 = 8'h55;
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_f_data", 32'(bus_f.data), 0);
    chk("rst_f_flags", {bus_f.flag_ready, bus_f.flag_error, bus_f.flag_busy}, 0);
    chk("rst_s_data", 32'(bus_s.data), 0);
    chk("rst_s_flags", {bus_s.flag_ready, bus_s.flag_error, bus_s.flag_busy}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int j = 0; j < 3; j++) begin
      bits[10*j] = 1'b0;
      for (int k = 0; k < 8; k++) bits[10*j+1+k] = fb[j][k];
      bits[10*j+9] = 1'b1;
    end
    in_f = bits[0];
    for (int n = 1; n <= 34; n++) begin
      @(posedge clk);
      #1;
      if (bus_f.flag_ready) begin
        if (fr_n < 3) begin fr_at[fr_n] = n; fr_d[fr_n] = bus_f.data; end
        fr_n++;
      end
      if (bus_f.flag_error) fe++;
      in_f = (n < 30) ? bits[n] : 1'b1;
    end
    chk("t1_ready_count", fr_n, 3);
    chk("t1_ready_at0", fr_at[0], 10);
    chk("t1_ready_at1", fr_at[1], 20);
    chk("t1_ready_at2", fr_at[2], 30);
    chk("t1_data0", 32'(fr_d[0]), 32'hA5);
    chk("t1_data1", 32'(fr_d[1]), 32'h00);
    chk("t1_data2", 32'(fr_d[2]), 32'hFF);
    chk("t1_errors", fe, 0);
    clr;
    frame(8'h3C, 1'b1);
    run(1'b1, 10);
    chk("t2_ready_count", rdy_n, 1);
    chk("t2_ready_at", rdy_at, 78);
    chk("t2_busy_first", busy_lo, 3);
    chk("t2_busy_last", busy_hi, 77);
    chk("t2_errors", err_n, 0);
    chk("t2_data", 32'(bus_s.data), 32'h3C);
    clr;
    run(1'b0, 2);
    run(1'b1, 20);
    chk("t3_busy_first", busy_lo, 3);
    chk("t3_busy_last", busy_hi, 5);
    chk("t3_ready_count", rdy_n, 0);
    chk("t3_errors", err_n, 0);
    chk("t3_data", 32'(bus_s.data), 32'h3C);
    clr;
    frame(8'h81, 1'b0);
    run(1'b0, 50);
    chk("t4_error_count", err_n, 1);
    chk("t4_error_at", err_at, 78);
    chk("t4_ready_count", rdy_n, 0);
    chk("t4_busy_last", busy_hi, 77);
    chk("t4_data_held", 32'(bus_s.data), 32'h3C);
    run(1'b1, 8);
    clr;
    frame(8'h81, 1'b1);
    run(1'b1, 10);
    chk("t4b_ready_count", rdy_n, 1);
    chk("t4b_ready_at", rdy_at, 78);
    chk("t4b_errors", err_n, 0);
    chk("t4b_data", 32'(bus_s.data), 32'h81);
    chk("both_flags", both_n, 0);
    clr;
    run(1'b0, 8);
    for (int k = 0; k < 4; k++) run(b55[k], 8);
    run(b55[4], 4);
    chk("t5_busy_pre", 32'(bus_s.flag_busy), 1);
    rst_n = 1'b0;
    #1;
    chk("t5_async_data", 32'(bus_s.data), 0);
    chk("t5_async_flags", {bus_s.flag_ready, bus_s.flag_error, bus_s.flag_busy}, 0);
    in_s = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("t5_held_flags", {bus_s.flag_ready, bus_s.flag_error, bus_s.flag_busy}, 0);
    rst_n = 1'b1;
    run(1'b1, 4);
    chk("t5_post_flags", {bus_s.flag_ready, bus_s.flag_error, bus_s.flag_busy}, 0);
    clr;
    frame(b55, 1'b1);
    run(1'b1, 10);
    chk("t5_ready_count", rdy_n, 1);
    chk("t5_ready_at", rdy_at, 78);
    chk("t5_data", 32'(bus_s.data), 32'h55);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_in.md
Name: uart_in

Overview:
- Serial UART receiver. It is the stage directly downstream of the existing one-bit-per-clock transmitter.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). The line idles high.
- Output: the recovered byte, plus a one-cycle ready pulse that feeds the byte-consumer logic.
- Bit period is parameterised. CLKS_PER_BIT=1 pairs directly with the existing transmitter; larger values serve an external line.

Parameters:
- CLKS_PER_BIT, 8: clocks per serial bit. Legal range ≥1.
- SYNC_STAGES, 2: synchroniser flops on the serial input. Legal range 0..3; 0 means no synchroniser, for on-chip loopback.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- in  in  1  serial line, idle high.
- data  out  8  last correctly framed byte. Registered; holds its value until the next good frame.
- flag_ready  out  1  one-cycle pulse: data has just been updated.
- flag_error  out  1  one-cycle pulse: framing error (stop bit sampled 0).
- flag_busy  out  1  high from start-bit detection until return to IDLE or BREAK.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; counters clear; shift register clears.
  - data=0x00, flag_ready=0, flag_error=0, flag_busy=0.
  - Synchroniser flops reset to 1, so no false start is seen on release.
  - A reset mid-frame aborts the frame with no pulses.
- line_s is the synchronised input; its latency is SYNC_STAGES clocks. All timing below is relative to line_s.
- HALF = (CLKS_PER_BIT-1)/2, using integer division. cnt is the clock counter within a bit; bit_idx is 0..7.
- IDLE:
  - If line_s==0 at cycle t0, set flag_busy=1.
  - If HALF==0, go to DATA with cnt=0.
  - Otherwise go to START with cnt=1.
- START:
  - cnt increments each clock.
  - At cnt==HALF: if line_s==0, go to DATA with cnt=0 and bit_idx=0.
  - At cnt==HALF with line_s==1: treat as a glitch. Go to IDLE, flag_busy=0, no pulses.
- DATA:
  - cnt counts 0..CLKS_PER_BIT-1.
  - At cnt==CLKS_PER_BIT-1: shift line_s into the MSB of the shift register (right shift, so the first bit lands in bit 0), clear cnt, and increment bit_idx.
  - After bit_idx 7 is sampled, go to STOP.
  - Data bit k is sampled at t0+HALF+(k+1)*CLKS_PER_BIT.
- STOP: the stop bit is sampled at t0+HALF+9*CLKS_PER_BIT.
  - line_s==1: data <= shift register, flag_ready=1 for the next cycle only, go to IDLE, flag_busy=0.
  - line_s==0: flag_error=1 for one cycle, data unchanged, go to BREAK, flag_busy=0.
- BREAK: wait until line_s==1, then go to IDLE. This means a held-low line produces exactly one error.
- Back-to-back frames: IDLE can detect a new start bit in the cycle immediately after STOP.
  - With CLKS_PER_BIT=1, one frame is received every 10 clocks with no gap.
- flag_ready and flag_error are never high together. Both are registered, so there are no combinational paths from in.
- Changes on in while busy are ignored except at the sample points.

Decomposition:
- Shared include/package uart_defs:
  - state encodings as localparams: IDLE, START, DATA, STOP, BREAK.
  - DATA_BITS=8.
  - FRAME_BITS=10.
- One sub-module, uart_sync:
  - parameterised N-flop synchroniser.
  - async active-low reset to 1.
  - passes straight through when N=0.
- The FSM, counters and shift register stay in uart_in.

Test Plan:
1. CLKS_PER_BIT=1, SYNC_STAGES=0, fed by the existing transmitter with 0xA5, then immediately 0x00 and 0xFF -> three flag_ready pulses exactly 10 clocks apart; data=0xA5, 0x00, 0xFF; flag_error never high.
2. CLKS_PER_BIT=8, SYNC_STAGES=2, frame 0x3C with start edge at line_s cycle t0 -> stop sampled at t0+75, flag_ready high at t0+76 only, data=0x3C, flag_busy high t0..t0+75.
3. CLKS_PER_BIT=8, in low for 2 clocks then high -> rejected at cnt==3; flag_busy falls; no flag_ready or flag_error; data keeps 0x3C.
4. CLKS_PER_BIT=8, frame 0x81 with stop bit 0, line then held low 50 clocks -> exactly one flag_error pulse; data stays 0x3C. Line then high 8 clocks, then a valid 0x81 frame -> flag_ready, data=0x81.
5. CLKS_PER_BIT=8, rst_n pulsed low while receiving bit 4 of 0x55 -> all outputs 0 immediately (async) with no pulse; after release, a full 0x55 frame gives flag_ready with data=0x55.
